bus_fifo_reader: RTL

//  Bus-slave read port that drains a strobe/ready/ack FIFO from its output end.

---
 rtl/bus_slave_pkg.sv | 20 ++
 rtl/bus_fifo_reader_if.sv | 27 ++
 rtl/bus_slave_regif.sv | 59 +++++
 rtl/bus_fifo_reader.sv | 118 +++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// Shared definitions for the 4-register bus slaves: FSM states, register map
// and CTRL bit positions.
package bus_slave_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    EMPTY    = 2'd1,
    VALID    = 2'd2
  } rd_state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_UFCLR_BIT = 1;
  localparam int BUS_DW         = 32;

endpackage

// File: rtl/bus_fifo_reader_if.sv
// FIFO read-side handshake plus system bus slave port of the FIFO reader.
interface bus_fifo_reader_if #(
  parameter int width = 8
);

  logic              FIFO_READY;
  logic [width-1:0]  FIFO_DATA;
  logic              FIFO_ACK;
  logic              BUS_SEL;
  logic              BUS_RD;
  logic              BUS_WR;
  logic [1:0]        BUS_ADDR;
  logic [31:0]       BUS_WDATA;
  logic [31:0]       BUS_RDATA;
  logic              BUS_RDY;

  modport slave (
    input  FIFO_READY, FIFO_DATA, BUS_SEL, BUS_RD, BUS_WR, BUS_ADDR, BUS_WDATA,
    output FIFO_ACK, BUS_RDATA, BUS_RDY
  );

  modport master (
    output FIFO_READY, FIFO_DATA, BUS_SEL, BUS_RD, BUS_WR, BUS_ADDR, BUS_WDATA,
    input  FIFO_ACK, BUS_RDATA, BUS_RDY
  );

endinterface

// File: rtl/bus_slave_regif.sv
// Generic 4-register bus slave front end: decode, one-cycle RDY/RDATA
// registration and the CTRL register.
module bus_slave_regif
  import bus_slave_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              bus_sel,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [1:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_rdy,
  input  logic [BUS_DW-1:0] data_word,
  input  logic [BUS_DW-1:0] status_word,
  input  logic [BUS_DW-1:0] count_word,
  output logic              rd_data_hit,
  output logic              ctrl_en,
  output logic              uf_clr
);

  logic              rd_acc;
  logic              wr_acc;
  logic [BUS_DW-1:0] read_mux;
  logic              wdata_unused;

  // A simultaneous RD and WR is a read; the write half is dropped.
  assign rd_acc       = bus_sel & bus_rd;
  assign wr_acc       = bus_sel & bus_wr & ~bus_rd;
  assign rd_data_hit  = rd_acc && (bus_addr == REG_DATA);
  assign uf_clr       = wr_acc && (bus_addr == REG_CTRL) && bus_wdata[CTRL_UFCLR_BIT];
  assign wdata_unused = ^bus_wdata[31:2];

  always_comb begin
    read_mux = '0;
    case (bus_addr)
      REG_DATA:   read_mux = data_word;
      REG_STATUS: read_mux = status_word;
      REG_CTRL:   read_mux = {{(BUS_DW-1){1'b0}}, ctrl_en};
      REG_COUNT:  read_mux = count_word;
      default:    read_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus_rdy   <= 1'b0;
      bus_rdata <= '0;
      ctrl_en   <= 1'b0;
    end else begin
      bus_rdy   <= rd_acc | wr_acc;
      bus_rdata <= rd_acc ? read_mux : '0;
      if (wr_acc && (bus_addr == REG_CTRL))
        ctrl_en <= bus_wdata[CTRL_EN_BIT];
    end
  end

endmodule

// File: rtl/bus_fifo_reader.sv
// Bus-slave read port that prefetches the FIFO head into a holding register;
// a DATA read consumes the held word and immediately refills it if possible.
module bus_fifo_reader
  import bus_slave_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input logic               CLK,
  input logic               RESET,
  bus_fifo_reader_if.slave  bus
);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [width-1:0]      hold;
  logic [cnt_width-1:0]  pop_cnt;
  logic                  underflow;
  logic                  valid;
  logic                  consume;
  logic                  load;
  logic                  rd_data_hit;
  logic                  ctrl_en;
  logic                  uf_clr;
  logic [BUS_DW-1:0]     data_word;
  logic [BUS_DW-1:0]     status_word;
  logic [BUS_DW-1:0]     count_word;

  assign valid   = (state == VALID);
  assign consume = rd_data_hit & valid;

  bus_slave_regif u_regif (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus_sel     (bus.BUS_SEL),
    .bus_rd      (bus.BUS_RD),
    .bus_wr      (bus.BUS_WR),
    .bus_addr    (bus.BUS_ADDR),
    .bus_wdata   (bus.BUS_WDATA),
    .bus_rdata   (bus.BUS_RDATA),
    .bus_rdy     (bus.BUS_RDY),
    .data_word   (data_word),
    .status_word (status_word),
    .count_word  (count_word),
    .rd_data_hit (rd_data_hit),
    .ctrl_en     (ctrl_en),
    .uf_clr      (uf_clr)
  );

  // An underflow read returns zero, so the stale hold is masked when not valid.
  always_comb begin
    data_word   = '0;
    count_word  = '0;
    if (valid)
      data_word[width-1:0] = hold;
    count_word[cnt_width-1:0] = pop_cnt;
    status_word = {29'b0, bus.FIFO_READY, underflow, valid};
  end

  // load doubles as the FIFO pop strobe: fill from EMPTY or bypass refill on consume.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      DISABLED: begin
        if (ctrl_en)
          state_next = EMPTY;
      end
      EMPTY: begin
        if (!ctrl_en)
          state_next = DISABLED;
        else if (bus.FIFO_READY) begin
          load       = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (consume) begin
          if (ctrl_en && bus.FIFO_READY)
            load = 1'b1;
          else if (ctrl_en)
            state_next = EMPTY;
          else
            state_next = DISABLED;
        end
      end
      default: state_next = DISABLED;
    endcase
  end

  assign bus.FIFO_ACK = load;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= DISABLED;
    else
      state <= state_next;
  end

  // A set in the same cycle as a W1C clear wins, so no underflow event is lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold      <= '0;
      pop_cnt   <= '0;
      underflow <= 1'b0;
    end else begin
      if (load)
        hold <= bus.FIFO_DATA;
      if (consume)
        pop_cnt <= pop_cnt + 1'b1;
      if (rd_data_hit && !valid)
        underflow <= 1'b1;
      else if (uf_clr)
        underflow <= 1'b0;
    end
  end

endmodule
